// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg -- shared definitions for the PC sequencer slice.
//   pc_seq_state_e : sequencer FSM state encoding (RUN / FLUSH)
//   PC_W           : fetch address width
//   IMM26_* / IMM19_* : branch immediate field positions inside the
//                    instruction word (B uses imm26, CB/B.cond use imm19)
package pc_seq_pkg;

  typedef enum logic [0:0] {
    PC_ST_RUN   = 1'b0,
    PC_ST_FLUSH = 1'b1
  } pc_seq_state_e;

  localparam int PC_W = 64;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = IMM26_MSB - IMM26_LSB + 1;

  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = IMM19_MSB - IMM19_LSB + 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if -- fetch and branch-redirect signals of the PC sequencer.
//   Fetch side : stall, fetch_ready (in), pc, pc_valid, flush (out)
//   Branch side: br_valid, br_uncond, br_taken, br_pc, br_instr (in), br_ready (out)
// Modports: master = the sequencer, slave = the pipeline around it.
//
// Handshake: a branch is accepted on a rising clk edge where br_valid and
// br_ready are both high; the requester keeps br_valid and its payload
// stable until that edge. A fetch of pc is consumed on an edge where
// pc_valid and fetch_ready are both high and stall is low.
interface pc_sequencer_if;
  import pc_seq_pkg::*;

  logic            stall;
  logic            fetch_ready;
  logic [PC_W-1:0] pc;
  logic            pc_valid;
  logic            flush;

  logic            br_valid;
  logic            br_uncond;
  logic            br_taken;
  logic [PC_W-1:0] br_pc;
  logic [31:0]     br_instr;
  logic            br_ready;

  modport master (
    input  stall, fetch_ready, br_valid, br_uncond, br_taken, br_pc, br_instr,
    output pc, pc_valid, flush, br_ready
  );

  modport slave (
    output stall, fetch_ready, br_valid, br_uncond, br_taken, br_pc, br_instr,
    input  pc, pc_valid, flush, br_ready
  );

endinterface

// File: rtl/branch_target_calc.sv
// branch_target_calc -- combinational branch target adder.
//   br_pc     : address of the branch instruction
//   br_instr  : branch instruction word
//   br_uncond : 1 = B (imm26), 0 = CB/B.cond (imm19)
//   target    : br_pc + (sign-extended immediate << 2), wrapping mod 2^64
module branch_target_calc
  import pc_seq_pkg::*;
(
  input  logic [PC_W-1:0] br_pc,
  input  logic [31:0]     br_instr,
  input  logic            br_uncond,
  output logic [PC_W-1:0] target
);

  logic [IMM26_W-1:0] imm26;
  logic [IMM19_W-1:0] imm19;
  logic [PC_W-1:0]    offset;

  assign imm26 = br_instr[IMM26_MSB:IMM26_LSB];
  assign imm19 = br_instr[IMM19_MSB:IMM19_LSB];

  // Opcode bits above imm26 do not affect the target.
  logic unused_opcode;
  assign unused_opcode = ^br_instr[31:IMM26_MSB+1];

  always_comb begin
    offset = '0;
    if (br_uncond) begin
      offset = {{(PC_W-IMM26_W){imm26[IMM26_W-1]}}, imm26};
    end else begin
      offset = {{(PC_W-IMM19_W){imm19[IMM19_W-1]}}, imm19};
    end
  end

  // Word-aligned offset; the add simply wraps at 64 bits.
  assign target = br_pc + (offset << 2);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer -- fetch PC generator with branch redirect and flush.
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   bus          : pc_sequencer_if.master (fetch + branch handshakes)
//   state_dbg    : current FSM state (0 = RUN, 1 = FLUSH)
//   taken_cnt    : accepted taken branches, saturating   (PC_SEQ_PERF_EN)
//   flush_cnt    : cycles spent in FLUSH, saturating      (PC_SEQ_PERF_EN)
// Parameters: RESET_PC (pc after reset), FLUSH_CYCLES (1..7, flush length).
// Optional feature macro: PC_SEQ_PERF_EN adds the two performance counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pc_sequencer_if.master        bus,
  output logic [0:0]            state_dbg
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]           taken_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam logic [0:0]      ST_RUN     = PC_ST_RUN;
  localparam logic [0:0]      ST_FLUSH   = PC_ST_FLUSH;
  localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [PC_W-1:0] PC_INC     = 64'd4;

  logic [0:0]      state;
  logic [2:0]      flush_ctr;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] target;
  logic            in_run;
  logic            take_br;
  logic            advance;

  branch_target_calc u_target (
    .br_pc     (bus.br_pc),
    .br_instr  (bus.br_instr),
    .br_uncond (bus.br_uncond),
    .target    (target)
  );

  assign in_run  = (state == ST_RUN);
  // Redirect wins over stall and fetch_ready.
  assign take_br = in_run && bus.br_valid && bus.br_taken;
  assign advance = in_run && !take_br && bus.fetch_ready && !bus.stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_RUN;
      flush_ctr <= '0;
      pc_q      <= RESET_PC;
    end else if (state == ST_RUN) begin
      if (take_br) begin
        pc_q      <= target;
        state     <= ST_FLUSH;
        flush_ctr <= FLUSH_LOAD;
      end else if (advance) begin
        pc_q <= pc_q + PC_INC;
      end
    end else begin
      // Leave on the edge where the counter reads 1 so flush is high for
      // exactly FLUSH_CYCLES cycles; <= also recovers from a stray 0.
      if (flush_ctr <= 3'd1) begin
        state     <= ST_RUN;
        flush_ctr <= '0;
      end else begin
        flush_ctr <= flush_ctr - 3'd1;
      end
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = in_run;
  assign bus.br_ready = in_run;
  assign bus.flush    = !in_run;
  assign state_dbg    = state;

`ifdef PC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (take_br && (taken_cnt != 32'hFFFF_FFFF)) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
      if (!in_run && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed testbench for pc_sequencer (default parameters:
// RESET_PC = 0, FLUSH_CYCLES = 2). Inputs change 1 time unit after a rising
// edge and outputs are observed at that same point, away from the edge.
module tb_pc_sequencer;

  logic       clk;
  logic       reset_n;
  logic [0:0] state_dbg;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] taken_cnt;
  logic [31:0] flush_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef PC_SEQ_PERF_EN
    ,
    .taken_cnt (taken_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic v, input logic uncond, input logic taken,
                          input logic [63:0] bpc, input logic [31:0] instr);
    bus.br_valid  = v;
    bus.br_uncond = uncond;
    bus.br_taken  = taken;
    bus.br_pc     = bpc;
    bus.br_instr  = instr;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n         = 1'b0;
    bus.stall       = 1'b0;
    bus.fetch_ready = 1'b1;
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    step();
    step();
    total_cnt++; if (bus.pc !== 64'h0) $display("FAIL rst_pc: got %h want %h", bus.pc, 64'h0); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0) $display("FAIL rst_flush: got %b want 0", bus.flush); else pass_cnt++;
    total_cnt++; if (bus.pc_valid !== 1'b1 || bus.br_ready !== 1'b1) $display("FAIL rst_valid_ready: got %b%b want 11", bus.pc_valid, bus.br_ready); else pass_cnt++;
    total_cnt++; if (state_dbg !== 1'b0) $display("FAIL rst_state: got %b want 0", state_dbg); else pass_cnt++;
`ifdef PC_SEQ_PERF_EN
    total_cnt++; if (taken_cnt !== 32'd0 || flush_cnt !== 32'd0) $display("FAIL rst_perf: got %0d/%0d want 0/0", taken_cnt, flush_cnt); else pass_cnt++;
`endif
  endtask

  // Release reset and watch the 0, 4, 8, C sequence.
  task automatic test_sequential();
    logic [63:0] exp_pc;
    reset_n = 1'b1;
    exp_pc  = 64'h0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (bus.pc !== exp_pc) $display("FAIL seq_pc%0d: got %h want %h", i, bus.pc, exp_pc); else pass_cnt++;
      if (i < 3) step();
      exp_pc = exp_pc + 64'h4;
    end
  endtask

  // B at 0x1000 with imm26 = -1 -> 0xFFC, then two flush cycles.
  task automatic test_taken_uncond();
    total_cnt++; if (bus.br_ready !== 1'b1) $display("FAIL b_ready_before: got %b want 1", bus.br_ready); else pass_cnt++;
    drive_br(1'b1, 1'b1, 1'b1, 64'h1000, 32'h17FF_FFFF);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.pc !== 64'hFFC) $display("FAIL b_target: got %h want %h", bus.pc, 64'hFFC); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) $display("FAIL b_flush1: flush/pc_valid got %b%b want 10", bus.flush, bus.pc_valid); else pass_cnt++;
    total_cnt++; if (bus.br_ready !== 1'b0 || state_dbg !== 1'b1) $display("FAIL b_flush1_ready: ready/state got %b%b want 01", bus.br_ready, state_dbg); else pass_cnt++;
    step();
    total_cnt++; if (bus.flush !== 1'b1 || bus.pc_valid !== 1'b0) $display("FAIL b_flush2: flush/pc_valid got %b%b want 10", bus.flush, bus.pc_valid); else pass_cnt++;
    total_cnt++; if (bus.pc !== 64'hFFC) $display("FAIL b_hold_in_flush: got %h want %h", bus.pc, 64'hFFC); else pass_cnt++;
    step();
    total_cnt++; if (bus.flush !== 1'b0 || bus.pc_valid !== 1'b1) $display("FAIL b_back_to_run: flush/pc_valid got %b%b want 01", bus.flush, bus.pc_valid); else pass_cnt++;
    total_cnt++; if (bus.pc !== 64'hFFC) $display("FAIL b_pc_at_run: got %h want %h", bus.pc, 64'hFFC); else pass_cnt++;
    step();
    total_cnt++; if (bus.pc !== 64'h1000) $display("FAIL b_resume: got %h want %h", bus.pc, 64'h1000); else pass_cnt++;
  endtask

  // CB at 0x2000, imm19 = 0x10, taken while stalled -> 0x2040.
  task automatic test_taken_with_stall();
    bus.stall = 1'b1;
    drive_br(1'b1, 1'b0, 1'b1, 64'h2000, 32'h5400_0200);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.pc !== 64'h2040) $display("FAIL cb_target_stall: got %h want %h", bus.pc, 64'h2040); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b1) $display("FAIL cb_flush: got %b want 1", bus.flush); else pass_cnt++;
    step();
    step();
    step();
    total_cnt++; if (bus.pc !== 64'h2040) $display("FAIL stall_hold: got %h want %h", bus.pc, 64'h2040); else pass_cnt++;
    bus.stall       = 1'b0;
    bus.fetch_ready = 1'b0;
    step();
    total_cnt++; if (bus.pc !== 64'h2040) $display("FAIL not_ready_hold: got %h want %h", bus.pc, 64'h2040); else pass_cnt++;
    bus.fetch_ready = 1'b1;
    step();
    total_cnt++; if (bus.pc !== 64'h2044) $display("FAIL ready_advance: got %h want %h", bus.pc, 64'h2044); else pass_cnt++;
  endtask

  // Not-taken CB at pc 0x100, then a request held across FLUSH.
  task automatic test_not_taken_and_hold();
    drive_br(1'b1, 1'b1, 1'b1, 64'h100, 32'h1400_0000);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    step();
    step();
    total_cnt++; if (bus.pc !== 64'h100) $display("FAIL nt_setup: got %h want %h", bus.pc, 64'h100); else pass_cnt++;
    drive_br(1'b1, 1'b0, 1'b0, 64'h100, 32'h5400_0200);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.pc !== 64'h104) $display("FAIL nt_advance: got %h want %h", bus.pc, 64'h104); else pass_cnt++;
    total_cnt++; if (bus.flush !== 1'b0 || state_dbg !== 1'b0) $display("FAIL nt_no_flush: flush/state got %b%b want 00", bus.flush, state_dbg); else pass_cnt++;
    // Enter FLUSH, then hold a new taken request through it.
    drive_br(1'b1, 1'b1, 1'b1, 64'h200, 32'h1400_0000);
    step();
    drive_br(1'b1, 1'b1, 1'b1, 64'h3000, 32'h1400_0000);
    total_cnt++; if (bus.br_ready !== 1'b0) $display("FAIL hold_ready1: got %b want 0", bus.br_ready); else pass_cnt++;
    step();
    total_cnt++; if (bus.br_ready !== 1'b0 || bus.pc !== 64'h200) $display("FAIL hold_ignored: ready %b pc %h want 0 %h", bus.br_ready, bus.pc, 64'h200); else pass_cnt++;
    step();
    total_cnt++; if (bus.br_ready !== 1'b1 || bus.pc !== 64'h200) $display("FAIL hold_run: ready %b pc %h want 1 %h", bus.br_ready, bus.pc, 64'h200); else pass_cnt++;
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.pc !== 64'h3000 || bus.flush !== 1'b1) $display("FAIL hold_accept: pc %h flush %b want %h 1", bus.pc, bus.flush, 64'h3000); else pass_cnt++;
    step();
    step();
  endtask

  // Reset asserted during the first FLUSH cycle.
  task automatic test_reset_mid_flush();
    drive_br(1'b1, 1'b1, 1'b1, 64'h5000, 32'h1400_0000);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.flush !== 1'b1) $display("FAIL mid_pre_flush: got %b want 1", bus.flush); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (bus.pc !== 64'h0 || bus.flush !== 1'b0) $display("FAIL mid_rst_async: pc %h flush %b want 0 0", bus.pc, bus.flush); else pass_cnt++;
    total_cnt++; if (state_dbg !== 1'b0 || bus.pc_valid !== 1'b1) $display("FAIL mid_rst_state: state %b pc_valid %b want 0 1", state_dbg, bus.pc_valid); else pass_cnt++;
    reset_n = 1'b1;
    step();
    total_cnt++; if (bus.pc !== 64'h4) $display("FAIL mid_resume: got %h want %h", bus.pc, 64'h4); else pass_cnt++;
  endtask

  // B at 0 with imm26 = -1 -> top of address space, then wrap to 0.
  task automatic test_wrap();
    drive_br(1'b1, 1'b1, 1'b1, 64'h0, 32'h17FF_FFFF);
    step();
    drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
    total_cnt++; if (bus.pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_target: got %h want %h", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC); else pass_cnt++;
    step();
    step();
    step();
    total_cnt++; if (bus.pc !== 64'h0) $display("FAIL wrap_advance: got %h want %h", bus.pc, 64'h0); else pass_cnt++;
  endtask

`ifdef PC_SEQ_PERF_EN
  task automatic test_perf();
    reset_n = 1'b0;
    #1;
    total_cnt++; if (taken_cnt !== 32'd0 || flush_cnt !== 32'd0) $display("FAIL perf_clear: got %0d/%0d want 0/0", taken_cnt, flush_cnt); else pass_cnt++;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_br(1'b1, 1'b1, 1'b1, 64'h100, 32'h1400_0000);
      step();
      drive_br(1'b0, 1'b0, 1'b0, 64'h0, 32'h0);
      step();
      step();
    end
    total_cnt++; if (taken_cnt !== 32'd3) $display("FAIL perf_taken: got %0d want 3", taken_cnt); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 32'd6) $display("FAIL perf_flush: got %0d want 6", flush_cnt); else pass_cnt++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_taken_uncond();
    test_taken_with_stall();
    test_not_taken_and_hold();
    test_reset_mid_flush();
    test_wrap();
`ifdef PC_SEQ_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0: PC value loaded on reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, range 1..7: number of cycles flush is held after a taken branch.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port stall  input  1  hazard hold; PC is not advanced while high.
REQ-006 SHALL have port fetch_ready  input  1  instruction memory accepts the current PC.
REQ-007 SHALL have port pc  output  64  current fetch address.
REQ-008 SHALL have port pc_valid  output  1  pc is a valid fetch request.
REQ-009 SHALL have port br_valid  input  1  execute stage presents a resolved branch.
REQ-010 SHALL have port br_uncond  input  1  1 = B (imm26 in br_instr[25:0]); 0 = CB/B.cond (imm19 in br_instr[23:5]).
REQ-011 SHALL have port br_taken  input  1  branch resolved taken.
REQ-012 SHALL have port br_pc  input  64  address of the branch instruction.
REQ-013 SHALL have port br_instr  input  32  branch instruction word.
REQ-014 SHALL have port br_ready  output  1  branch accepted this cycle when br_valid is also high.
REQ-015 SHALL have port flush  output  1  kill younger pipeline stages.

Function
REQ-016 SHALL compute target = br_pc + (sign-extended immediate << 2), modulo 2^64; immediate sign bit = br_instr[25] (uncond) or br_instr[23] (cond).
REQ-017 SHALL implement a two-state FSM: RUN and FLUSH.
REQ-018 In RUN, pc_valid SHALL be 1 and br_ready SHALL be 1.
REQ-019 In RUN with fetch_ready=1, stall=0 and no taken branch accepted, pc SHALL advance by 4 at the next edge, wrapping modulo 2^64.
REQ-020 In RUN with stall=1 or fetch_ready=0 and no taken branch accepted, pc SHALL hold.
REQ-021 A branch accepted with br_taken=0 SHALL have no effect on pc or state.
REQ-022 A branch accepted with br_taken=1 SHALL load pc with target at the next edge, enter FLUSH, and load the flush counter with FLUSH_CYCLES; this takes priority over stall and fetch_ready.
REQ-023 In FLUSH, flush SHALL be 1, pc_valid SHALL be 0, br_ready SHALL be 0, and pc SHALL hold; the counter SHALL decrement each cycle.
REQ-024 FLUSH SHALL return to RUN on the edge where the counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles.
REQ-025 br_valid during FLUSH SHALL be ignored; the requester SHALL hold it until br_ready is high.
REQ-026 flush SHALL be 0 in RUN.

Reset
REQ-027 Asserting reset_n low SHALL immediately force pc=RESET_PC, state=RUN, flush=0, counter=0, and perf counters=0, including mid-FLUSH.
REQ-028 The first pc increment SHALL occur on the first qualifying edge after reset_n deasserts.

Configuration
REQ-029 With macro PC_SEQ_PERF_EN defined, SHALL add outputs taken_cnt (32) and flush_cnt (32), counting accepted taken branches and FLUSH-state cycles respectively; both saturate at 32'hFFFFFFFF.
REQ-030 Without PC_SEQ_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 The shared package pc_seq_pkg SHALL hold the FSM state enum, the PC width constant (64), and the instruction-field bit positions for imm26 and imm19.
REQ-032 Target calculation SHALL be a combinational sub-module branch_target_calc (inputs br_pc, br_instr, br_uncond; output target).

Verification
REQ-033 Reset release with RESET_PC=0 and fetch_ready=1, stall=0 -> pc sequence 0x0, 0x4, 0x8, 0xC.
REQ-034 B at br_pc=0x1000 with imm26=0x3FFFFFF, taken -> pc=0xFFC next cycle; flush high for 2 cycles; pc_valid low for those 2 cycles.
REQ-035 CB at br_pc=0x2000 with imm19=0x10, taken, with stall=1 in the same cycle -> pc=0x2040; redirect overrides stall.
REQ-036 Not-taken CB at pc=0x100 with fetch_ready=1 -> pc=0x104 and flush stays 0; br_valid during FLUSH -> br_ready=0 and the request is held until RUN.
REQ-037 reset_n pulsed low during the first FLUSH cycle -> pc=RESET_PC and flush=0 immediately; RUN resumes.
REQ-038 With PC_SEQ_PERF_EN and 3 taken branches at FLUSH_CYCLES=2 -> taken_cnt=3 and flush_cnt=6; pc=0xFFFFFFFFFFFFFFFC advancing -> pc=0x0.
